// File: rtl/maxpool_stream.sv
// Streaming POOLxPOOL max-pooling over a raster-order pixel stream.
// A line buffer of partial column maxima replaces a full-window input.
module maxpool_stream #(
    parameter int DATA_W = 10,
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4,
    parameter int POOL   = 2,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);
    localparam int NOC = IMG_W / POOL;
    localparam int NOR = IMG_H / POOL;
    localparam int PW  = $clog2(POOL);
    localparam int OCW = (NOC > 1) ? $clog2(NOC) : 1;
    localparam int ORW = (NOR > 1) ? $clog2(NOR) : 1;
    localparam logic [PW-1:0]  P_LAST  = PW'(POOL - 1);
    localparam logic [OCW-1:0] OC_LAST = OCW'(NOC - 1);
    localparam logic [ORW-1:0] OR_LAST = ORW'(NOR - 1);

    if ((IMG_W % POOL) != 0 || (IMG_H % POOL) != 0 || POOL < 2 || POOL > 4) begin : g_bad_geometry
        $error("maxpool_stream: IMG_W/IMG_H must be multiples of POOL, POOL in 2..4");
    end

    // Column position split into (pc, oc), row position into (pr, orow).
    logic [PW-1:0]     pc_q, pc_d, pr_q, pr_d;
    logic [OCW-1:0]    oc_q, oc_d;
    logic [ORW-1:0]    or_q, or_d;
    logic [DATA_W-1:0] h_q, h_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] line_buf [NOC];

    logic              accept, col_end, row_end, win_done, buf_we;
    logic [DATA_W-1:0] hn, v;

    function automatic logic [DATA_W-1:0] vmax(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic a_gt;
        if (SIGNED != 0) a_gt = $signed(a) > $signed(b);
        else             a_gt = a > b;
        return a_gt ? a : b;
    endfunction

    assign in_ready = !clear && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign col_end  = (pc_q == P_LAST);
    assign row_end  = (pr_q == P_LAST);
    assign hn       = (pc_q == '0) ? in_data : vmax(h_q, in_data);
    assign v        = (pr_q == '0) ? hn : vmax(line_buf[oc_q], hn);
    assign win_done = accept && col_end && row_end;
    assign buf_we   = accept && col_end && !row_end;

    always_comb begin
        pc_d        = pc_q;
        oc_d        = oc_q;
        pr_d        = pr_q;
        or_d        = or_q;
        h_d         = h_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (clear) begin
            pc_d        = '0;
            oc_d        = '0;
            pr_d        = '0;
            or_d        = '0;
            h_d         = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
            if (accept) begin
                h_d = hn;
                if (col_end) begin
                    pc_d = '0;
                    if (oc_q == OC_LAST) begin
                        oc_d = '0;
                        if (row_end) begin
                            pr_d = '0;
                            or_d = (or_q == OR_LAST) ? '0 : or_q + 1'b1;
                        end else begin
                            pr_d = pr_q + 1'b1;
                        end
                    end else begin
                        oc_d = oc_q + 1'b1;
                    end
                end else begin
                    pc_d = pc_q + 1'b1;
                end
                // A completing window reloads the output register even while it is being popped.
                if (win_done) begin
                    out_data_d  = v;
                    out_valid_d = 1'b1;
                    out_last_d  = (oc_q == OC_LAST) && (or_q == OR_LAST);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= '0;
            oc_q        <= '0;
            pr_q        <= '0;
            or_q        <= '0;
            h_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            oc_q        <= oc_d;
            pr_q        <= pr_d;
            or_q        <= or_d;
            h_q         <= h_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Stale entries are harmless: every entry is rewritten at pr==0 before it is read.
    always_ff @(posedge clk) begin
        if (buf_we) line_buf[oc_q] <= v;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
endmodule
